gf180mcu_fd_sc_mcu9t5v0__invz_arb4: RTL and testbench
=====================================================

GF180MCU_FD_SC_MCU9T5V0__INVZ_ARB4 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__invz_arb4

Interface
REQ-001 Parameter DEAD, default 1, range 1..7: bus-idle (dead) cycles inserted between any two drive grants.
REQ-002 Parameter MAXHOLD, default 8, range 2..255: maximum consecutive drive cycles while another requester waits.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, asynchronous, active-high.
REQ-005 REQ  input  4  per-requester bus-drive request, level-sensitive.
REQ-006 EN   output 4  registered enables to four tristate inverter drivers sharing one net; at most one bit high.
REQ-007 OWNER output 2  binary index of the current/last granted requester.
REQ-008 BUSY output 1  high when the state is not IDLE.

Function
REQ-009 Three states SHALL exist: IDLE, DRIVE, DEAD.
REQ-010 All outputs SHALL come directly from flops; EN SHALL never have more than one bit high in any cycle, including across transitions.
REQ-011 IDLE: EN=0; if any REQ bit is sampled high at an edge, the arbiter SHALL pick a winner round-robin, searching from (PTR+1) mod 4 upward, and enter DRIVE with EN[winner]=1 at that same edge (1-cycle REQ-to-EN latency).
REQ-012 On every grant, PTR SHALL load the winner index and OWNER SHALL load the winner index.
REQ-013 DRIVE: EN[OWNER] stays high while REQ[OWNER]=1 and the hold counter has not expired.
REQ-014 The hold counter SHALL reset to 1 on grant and increment each DRIVE cycle, saturating at MAXHOLD.
REQ-015 DRIVE exits to DEAD (EN=0 at that edge) when REQ[OWNER] is sampled low, or when the hold count equals MAXHOLD and any other REQ bit is high.
REQ-016 If the hold count equals MAXHOLD and no other REQ bit is high, DRIVE SHALL continue indefinitely with no dead cycle.
REQ-017 DEAD SHALL last exactly DEAD cycles with EN=0; a dead counter loads DEAD-1 on entry and decrements.
REQ-018 At the edge ending the last DEAD cycle, the arbiter SHALL arbitrate REQ as in IDLE: on a winner, enter DRIVE; otherwise enter IDLE.
REQ-019 REQ changes during DEAD other than at the final arbitration edge SHALL have no effect.
REQ-020 A requester preempted by MAXHOLD that still requests SHALL be regranted only after every other pending requester has been served, per round-robin order.
REQ-021 Requester drop and a new REQ rising in the same cycle SHALL still pass through DEAD before the new grant.
REQ-022 OWNER SHALL hold its value through DEAD and IDLE.

Reset
REQ-023 RST high SHALL immediately (asynchronously) force EN=0, BUSY=0, OWNER=0, state=IDLE, PTR=3, and both counters=0.
REQ-024 RST asserted mid-DRIVE or mid-DEAD SHALL abort without any dead-time guarantee beyond EN=0.
REQ-025 After RST deassertion, the first grant SHALL favour requester 0.

Structure
REQ-026 The shared package SHALL hold the state enum (IDLE, DRIVE, DEAD), the requester count constant 4, and the counter width constants.
REQ-027 The round-robin picker SHALL be one combinational sub-module, gf180mcu_fd_sc_mcu9t5v0__invz_arb4_rrpick (inputs req[3:0], ptr[1:0]; outputs valid, idx[1:0]).
REQ-028 The design SHALL contain no latches, and no tristate logic inside the block.

Verification
REQ-029 Reset, then REQ=0001 at cycle 0: EN=0001 and OWNER=0 after edge 1; REQ=0000 at cycle 5: EN=0000 next edge, IDLE after 1 dead cycle.
REQ-030 REQ=1111 held, DEAD=2, MAXHOLD=4: grants in order 0,1,2,3,0; each lasts 4 cycles, separated by exactly 2 EN=0 cycles.
REQ-031 REQ=0100 alone held for 300 cycles, MAXHOLD=8: EN=0100 continuously, with no dead cycle.
REQ-032 Owner 1 drops while REQ[3] rises in the same cycle, DEAD=3: EN=0000 for 3 cycles, then EN=1000.
REQ-033 RST pulsed mid-DRIVE with EN=0010: EN=0000 within the same cycle (no clock edge); the next grant with REQ=1010 goes to requester 1.
REQ-034 Every test SHALL carry an assertion that $onehot0(EN) holds every cycle, and that an EN bit falling is never followed by a different EN bit rising within DEAD cycles.

Source files
------------

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_arb4_pkg.sv
// Shared definitions for the four-way tristate-inverter drive arbiter.
//   NUM_REQ  : number of requesters / driver enables
//   IDX_W    : width of a requester index
//   HOLD_W   : width of the consecutive-drive hold counter (MAXHOLD <= 255)
//   DEAD_W   : width of the bus-idle counter (DEAD <= 7)
//   arb_state_e : arbiter state (idle, driving, dead-time)
package gf180mcu_fd_sc_mcu9t5v0__invz_arb4_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned HOLD_W  = 8;
  localparam int unsigned DEAD_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DEAD  = 2'd2
  } arb_state_e;

  // One-hot enable pattern for a requester index.
  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    idx_to_onehot = NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_arb4_if.sv
// Request/enable bundle between the requesters and the drive arbiter.
//   req   : per-requester drive request, level-sensitive (requester -> arbiter)
//   en    : registered driver enables, at most one high (arbiter -> drivers)
//   owner : index of the current/last granted requester
//   busy  : arbiter not idle
// master = requester side, slave = arbiter side.
interface gf180mcu_fd_sc_mcu9t5v0__invz_arb4_if;
  import gf180mcu_fd_sc_mcu9t5v0__invz_arb4_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] en;
  logic [IDX_W-1:0]   owner;
  logic               busy;

  modport master (output req, input en, input owner, input busy);
  modport slave  (input req, output en, output owner, output busy);

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_arb4_rrpick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : last granted index; search starts at (ptr+1) mod NUM_REQ
//   valid : any request present
//   idx   : first requesting index in round-robin order (ptr when !valid)
module gf180mcu_fd_sc_mcu9t5v0__invz_arb4_rrpick
  import gf180mcu_fd_sc_mcu9t5v0__invz_arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  // Walk ptr+1 .. ptr+NUM_REQ (wrapping); first hit wins, so ptr itself is last.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'(32'(ptr) + k);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invz_arb4.sv
// Arbiter for four tristate inverter drivers sharing one net. Grants the net
// round-robin, bounds a holder's tenure to MAXHOLD cycles while others wait,
// and inserts DEAD bus-idle cycles between any two drive grants so that two
// drivers never overlap.
//   DEAD    : idle cycles between grants (1..7)
//   MAXHOLD : max consecutive drive cycles while another requester waits (2..255)
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   bus     : slave side of the request/enable bundle (req in; en/owner/busy out)
module gf180mcu_fd_sc_mcu9t5v0__invz_arb4
  import gf180mcu_fd_sc_mcu9t5v0__invz_arb4_pkg::*;
#(
  parameter int unsigned DEAD    = 1,
  parameter int unsigned MAXHOLD = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  gf180mcu_fd_sc_mcu9t5v0__invz_arb4_if.slave   bus
);

  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAXHOLD);
  localparam logic [DEAD_W-1:0] DEAD_LOAD = DEAD_W'(DEAD - 1);
  localparam logic [IDX_W-1:0]  PTR_RST   = IDX_W'(NUM_REQ - 1);

  arb_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] en_q, en_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [DEAD_W-1:0]  dead_q, dead_d;
  logic               busy_q, busy_d;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] own_mask;
  logic               own_req;
  logic               other_req;
  logic               hold_max;
  logic               grant;

  gf180mcu_fd_sc_mcu9t5v0__invz_arb4_rrpick u_rrpick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Owner's own request and whether anybody else is waiting.
  always_comb begin
    own_mask  = idx_to_onehot(owner_q);
    own_req   = bus.req[owner_q];
    other_req = |(bus.req & ~own_mask);
    hold_max  = (hold_q == HOLD_MAX);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    dead_d  = dead_q;
    grant   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        en_d = '0;
        if (pick_valid) begin
          grant = 1'b1;
        end
      end

      ST_DRIVE: begin
        // Release on owner drop, or on tenure expiry only if someone else waits;
        // a lone requester keeps the net with no dead gap.
        if (!own_req || (hold_max && other_req)) begin
          state_d = ST_DEAD;
          en_d    = '0;
          dead_d  = DEAD_LOAD;
        end else if (!hold_max) begin
          hold_d = hold_q + 1'b1;
        end
      end

      ST_DEAD: begin
        en_d = '0;
        // Requests are only looked at on the edge that ends the last dead cycle.
        if (dead_q == '0) begin
          if (pick_valid) begin
            grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          dead_d = dead_q - 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        en_d    = '0;
      end
    endcase

    if (grant) begin
      state_d = ST_DRIVE;
      en_d    = idx_to_onehot(pick_idx);
      owner_d = pick_idx;
      ptr_d   = pick_idx;
      hold_d  = HOLD_W'(1);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset drops every enable immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      en_q    <= '0;
      owner_q <= '0;
      ptr_q   <= PTR_RST;
      hold_q  <= '0;
      dead_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      dead_q  <= dead_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.en    = en_q;
  assign bus.owner = owner_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__invz_arb4.sv
// Bench for the four-way drive arbiter. Three instances (DEAD/MAXHOLD = 1/8,
// 2/4, 3/4) see the same request stream and are compared every cycle against
// a behavioural model, plus directed scenario checks.
`timescale 1ns/1ps
module tb_gf180mcu_fd_sc_mcu9t5v0__invz_arb4;

  localparam int N_DUT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;

  logic [3:0] en_w    [N_DUT];
  logic [1:0] owner_w [N_DUT];
  logic       busy_w  [N_DUT];

  int unsigned vectors;
  int unsigned errs;

  // model state: driving index (-1 none), owner, last grant, cycles held, dead cycles left
  int m_en    [N_DUT];
  int m_owner [N_DUT];
  int m_last  [N_DUT];
  int m_held  [N_DUT];
  int m_gap   [N_DUT];

  // enable-gap tracker
  logic [3:0] t_prev  [N_DUT];
  bit         t_fell  [N_DUT];
  int         t_zeros [N_DUT];

  int order[$];
  int runs[$];
  int gaps[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int unsigned DD = (g == 0) ? 1 : (g == 1) ? 2 : 3;
    localparam int unsigned MH = (g == 0) ? 8 : 4;

    gf180mcu_fd_sc_mcu9t5v0__invz_arb4_if u_if ();

    assign u_if.req   = req;
    assign en_w[g]    = u_if.en;
    assign owner_w[g] = u_if.owner;
    assign busy_w[g]  = u_if.busy;

    gf180mcu_fd_sc_mcu9t5v0__invz_arb4 #(
      .DEAD    (DD),
      .MAXHOLD (MH)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );
  end

  function automatic int dead_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 3;
  endfunction

  function automatic int hold_of(input int k);
    return (k == 0) ? 8 : 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N_DUT; k++) begin
      m_en[k]    = -1;
      m_owner[k] = 0;
      m_last[k]  = 3;
      m_held[k]  = 0;
      m_gap[k]   = 0;
      t_prev[k]  = 4'b0000;
      t_fell[k]  = 1'b0;
      t_zeros[k] = 0;
    end
  endtask

  task automatic model_pick(input int k, input logic [3:0] r);
    m_en[k] = -1;
    for (int i = 1; i <= 4; i++) begin
      int j;
      j = (m_last[k] + i) % 4;
      if (r[j]) begin
        m_en[k]    = j;
        m_owner[k] = j;
        m_last[k]  = j;
        m_held[k]  = 1;
        break;
      end
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r);
    logic [3:0] others;
    if (m_en[k] >= 0) begin
      others = r & ~(4'b0001 << m_en[k]);
      if (!r[m_en[k]] || (m_held[k] >= hold_of(k) && others != 4'b0000)) begin
        m_en[k]  = -1;
        m_gap[k] = dead_of(k);
      end else if (m_held[k] < hold_of(k)) begin
        m_held[k]++;
      end
    end else if (m_gap[k] > 1) begin
      m_gap[k]--;
    end else begin
      m_gap[k] = 0;
      model_pick(k, r);
    end
  endtask

  function automatic logic [3:0] exp_en(input int k);
    return (m_en[k] < 0) ? 4'b0000 : (4'b0001 << m_en[k]);
  endfunction

  task automatic compare_all();
    for (int k = 0; k < N_DUT; k++) begin
      chk($sformatf("en%0d", k), 32'(en_w[k]), 32'(exp_en(k)));
      chk($sformatf("owner%0d", k), 32'(owner_w[k]), 32'(m_owner[k]));
      chk($sformatf("busy%0d", k), 32'(busy_w[k]), 32'((m_en[k] >= 0) || (m_gap[k] > 0)));
      chk($sformatf("onehot0_%0d", k), 32'($onehot0(en_w[k])), 32'd1);
      if (en_w[k] == 4'b0000) begin
        if (t_prev[k] != 4'b0000) begin
          t_fell[k]  = 1'b1;
          t_zeros[k] = 0;
        end
        if (t_fell[k]) t_zeros[k]++;
      end else begin
        chk($sformatf("nohop%0d", k), 32'(t_prev[k] == 4'b0000 || t_prev[k] == en_w[k]), 32'd1);
        if (t_prev[k] == 4'b0000 && t_fell[k]) begin
          chk($sformatf("deadgap%0d", k), 32'(t_zeros[k] >= dead_of(k)), 32'd1);
          t_fell[k] = 1'b0;
        end
      end
      t_prev[k] = en_w[k];
    end
  endtask

  // Called at a falling edge: drive req, let one rising edge pass, check.
  task automatic tick(input logic [3:0] r);
    req = r;
    @(posedge clk);
    for (int k = 0; k < N_DUT; k++) begin
      if (rst) model_reset();
      else     model_step(k, r);
    end
    @(negedge clk);
    compare_all();
  endtask

  // Called at a falling edge: asynchronous reset pulse between clock edges.
  task automatic apply_reset();
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [3:0] pv;
    logic [3:0] r;
    int run, gap, bad, zeros;

    vectors = 0;
    errs    = 0;
    rst     = 1'b1;
    req     = 4'b0000;
    model_reset();

    // reset state
    @(negedge clk);
    compare_all();
    tick(4'b0000);
    rst = 1'b0;

    // single requester grant and release
    tick(4'b0001);
    chk("s1_en", 32'(en_w[0]), 32'h1);
    chk("s1_owner", 32'(owner_w[0]), 32'h0);
    repeat (4) tick(4'b0001);
    tick(4'b0000);
    chk("s1_drop_en", 32'(en_w[0]), 32'h0);
    chk("s1_dead_busy", 32'(busy_w[0]), 32'h1);
    tick(4'b0000);
    chk("s1_idle", 32'(busy_w[0]), 32'h0);

    // all requesting: round-robin order, tenure and dead gaps on DEAD=2/MAXHOLD=4
    apply_reset();
    pv  = 4'b0000;
    run = 0;
    gap = 0;
    for (int c = 0; c < 40; c++) begin
      tick(4'b1111);
      if (en_w[1] != 4'b0000) begin
        if (pv == 4'b0000) begin
          order.push_back(int'(owner_w[1]));
          if (gap > 0) gaps.push_back(gap);
          gap = 0;
        end
        run++;
      end else begin
        if (pv != 4'b0000) begin
          runs.push_back(run);
          run = 0;
        end
        gap++;
      end
      pv = en_w[1];
    end
    for (int i = 0; i < 5; i++)
      chk($sformatf("s2_order%0d", i), 32'((i < order.size()) ? order[i] : -1), 32'(i % 4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s2_run%0d", i), 32'((i < runs.size()) ? runs[i] : -1), 32'd4);
      chk($sformatf("s2_gap%0d", i), 32'((i < gaps.size()) ? gaps[i] : -1), 32'd2);
    end

    // lone requester beyond MAXHOLD keeps the net
    apply_reset();
    tick(4'b0100);
    chk("s3_grant", 32'(en_w[0]), 32'h4);
    bad = 0;
    for (int c = 0; c < 299; c++) begin
      tick(4'b0100);
      if (en_w[0] != 4'b0100) bad++;
    end
    chk("s3_nodead", 32'(bad), 32'd0);

    // owner drop with simultaneous new request, DEAD=3
    apply_reset();
    repeat (3) tick(4'b0010);
    chk("s4_owner1", 32'(en_w[2]), 32'h2);
    tick(4'b1000);
    zeros = 0;
    for (int c = 0; c < 10 && en_w[2] == 4'b0000; c++) begin
      zeros++;
      tick(4'b1000);
    end
    chk("s4_zeros", 32'(zeros), 32'd3);
    chk("s4_en", 32'(en_w[2]), 32'h8);

    // asynchronous reset mid-drive, then first grant favours the lowest index
    apply_reset();
    tick(4'b0010);
    chk("s5_drive", 32'(en_w[0]), 32'h2);
    #2 rst = 1'b1;
    model_reset();
    #1 chk("s5_async_en", 32'(en_w[0]), 32'h0);
    compare_all();
    @(negedge clk);
    rst = 1'b0;
    tick(4'b1010);
    chk("s5_regrant", 32'(owner_w[0]), 32'h1);
    chk("s5_regrant_en", 32'(en_w[0]), 32'h2);

    // randomized traffic with sticky requests and occasional resets
    r = 4'b0000;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3) == 0) r = 4'($urandom);
      if ($urandom_range(199) == 0) apply_reset();
      else tick(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
